// File: rtl/dac_channel_pipeline_if.sv
// Sample input strobe and AD5662 SPI lines for one DAC channel.
// The sample source is the master; the channel pipeline is the slave.
interface dac_channel_pipeline_if #(
  parameter int DATA_W = 16
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample_in;
  logic              SYNC;
  logic              SCLK;
  logic              DIN;

  modport master (output sample_valid, output sample_in, input SYNC, input SCLK, input DIN);
  modport slave  (input sample_valid, input sample_in, output SYNC, output SCLK, output DIN);
endinterface

// File: rtl/dac_channel_pipeline.sv
// Per-channel DAC output path: reference subtraction, one-pole LPF/HPF, dead band, gain,
// hysteretic threshold with refractory event, and a self-timed AD5662 SPI serializer.
module dac_channel_pipeline #(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int SCLK_DIV   = 2,
  parameter int SYNC_GAP   = 4,
  parameter int SPI_CTRL_W = 8
) (
  input  logic                  dataclk,
  input  logic                  reset,
  dac_channel_pipeline_if.slave bus,
  input  logic                  ref_en,
  input  logic [DATA_W-1:0]     software_reference,
  input  logic                  filter_en,
  input  logic                  filter_type,
  input  logic [COEF_W-1:0]     filter_coefficient,
  input  logic [6:0]            noise_suppress,
  input  logic [2:0]            gain,
  input  logic                  en,
  input  logic                  use_sequencer,
  input  logic [DATA_W-1:0]     sequencer_in,
  input  logic [DATA_W-1:0]     thrsh,
  input  logic [DATA_W-1:0]     hyst,
  input  logic                  thrsh_pol,
  input  logic [15:0]           refractory,
  output logic                  thrsh_out,
  output logic                  thrsh_event,
  output logic [DATA_W-1:0]     register,
  output logic                  busy,
  output logic                  overrun
);

  localparam int FRAME_W = SPI_CTRL_W + DATA_W;
  localparam int S_W     = DATA_W + COEF_W;
  localparam int D_W     = DATA_W + 2;
  localparam int P_W     = D_W + COEF_W + 1;
  localparam int WIDE    = DATA_W + COEF_W + 8;
  localparam int CNT_MAX = (SCLK_DIV > SYNC_GAP) ? SCLK_DIV : SYNC_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [DATA_W-1:0]      MID    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [WIDE-1:0] SMAX_W = WIDE'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [WIDE-1:0] SMIN_W = ~SMAX_W;

  typedef enum logic [1:0] {IDLE, SHIFT_HI, SHIFT_LO, GAP} spi_state_t;

  function automatic logic signed [DATA_W-1:0] sat_dw(input logic signed [WIDE-1:0] v);
    if (v > SMAX_W) return SMAX_W[DATA_W-1:0];
    if (v < SMIN_W) return SMIN_W[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] in_s;
  logic signed [DATA_W-1:0] ref_s;
  logic                     valid1;
  logic signed [DATA_W-1:0] x1;

  assign in_s  = {~bus.sample_in[DATA_W-1], bus.sample_in[DATA_W-2:0]};
  assign ref_s = {~software_reference[DATA_W-1], software_reference[DATA_W-2:0]};

  always_ff @(posedge dataclk) begin
    if (reset) begin
      valid1 <= 1'b0;
      x1     <= '0;
    end else begin
      valid1 <= bus.sample_valid;
      if (bus.sample_valid)
        x1 <= ref_en ? sat_dw(WIDE'(in_s) - WIDE'(ref_s)) : in_s;
    end
  end

  // S carries COEF_W fraction bits below the sample-width integer part; d cannot exceed D_W bits.
  logic signed [S_W-1:0]    s_acc;
  logic signed [DATA_W-1:0] s_hi;
  logic signed [D_W-1:0]    d;
  logic signed [P_W-1:0]    prod;
  logic signed [DATA_W-1:0] filt;
  logic                     valid2;
  logic signed [DATA_W-1:0] y2;

  assign s_hi = s_acc[S_W-1 -: DATA_W];
  assign d    = D_W'(x1) - D_W'(s_hi);
  assign prod = P_W'(d) * P_W'($signed({1'b0, filter_coefficient}));

  always_comb begin
    filt = x1;
    if (filter_en)
      filt = filter_type ? sat_dw(WIDE'(d)) : s_hi;
  end

  always_ff @(posedge dataclk) begin
    if (reset) begin
      valid2 <= 1'b0;
      y2     <= '0;
      s_acc  <= '0;
    end else begin
      valid2 <= valid1;
      if (valid1) begin
        y2 <= filt;
        if (filter_en)
          s_acc <= s_acc + S_W'(prod);
      end
    end
  end

  logic signed [WIDE-1:0]   y_w;
  logic signed [WIDE-1:0]   mag_w;
  logic signed [WIDE-1:0]   red_w;
  logic signed [WIDE-1:0]   vs_w;
  logic signed [WIDE-1:0]   gained_w;
  logic signed [DATA_W-1:0] vs_d;
  logic signed [DATA_W-1:0] scaled;
  logic [DATA_W-1:0]        v_ob;
  logic [DATA_W-1:0]        scaled_ob;
  logic [DATA_W-1:0]        word_new;

  always_comb begin
    y_w   = WIDE'(y2);
    mag_w = y_w[WIDE-1] ? -y_w : y_w;
    red_w = mag_w - $signed(WIDE'({noise_suppress, 4'b0000}));
    if (red_w[WIDE-1])
      red_w = '0;
    vs_w     = y_w[WIDE-1] ? -red_w : red_w;
    gained_w = vs_w <<< gain;
  end

  assign vs_d      = vs_w[DATA_W-1:0];
  assign scaled    = sat_dw(gained_w);
  assign v_ob      = {~vs_d[DATA_W-1], vs_d[DATA_W-2:0]};
  assign scaled_ob = {~scaled[DATA_W-1], scaled[DATA_W-2:0]};
  assign word_new  = use_sequencer ? sequencer_in : (en ? scaled_ob : MID);

  always_ff @(posedge dataclk) begin
    if (reset)
      register <= MID;
    else if (valid2)
      register <= word_new;
  end

  logic [DATA_W:0]   upper_sum;
  logic [DATA_W-1:0] upper;
  logic [DATA_W-1:0] lower;
  logic              assert_cond;
  logic              release_cond;
  logic              fire;
  logic [15:0]       refcnt;

  assign upper_sum    = {1'b0, thrsh} + {1'b0, hyst};
  assign upper        = upper_sum[DATA_W] ? '1 : upper_sum[DATA_W-1:0];
  assign lower        = (thrsh >= hyst) ? (thrsh - hyst) : '0;
  assign assert_cond  = thrsh_pol ? (v_ob >= thrsh) : (v_ob <= thrsh);
  assign release_cond = thrsh_pol ? (v_ob < lower) : (v_ob > upper);
  assign fire         = valid2 && en && !thrsh_out && assert_cond;

  // The refractory counter ticks on input strobes, so back-to-back samples drain it early.
  always_ff @(posedge dataclk) begin
    if (reset) begin
      thrsh_out   <= 1'b0;
      thrsh_event <= 1'b0;
      refcnt      <= '0;
    end else begin
      thrsh_event <= fire && (refcnt == 16'd0);
      if (!en)
        thrsh_out <= 1'b0;
      else if (fire)
        thrsh_out <= 1'b1;
      else if (valid2 && thrsh_out && release_cond)
        thrsh_out <= 1'b0;
      if (fire && (refcnt == 16'd0))
        refcnt <= refractory;
      else if (bus.sample_valid && (refcnt != 16'd0))
        refcnt <= refcnt - 16'd1;
    end
  end

  spi_state_t        state, state_n;
  logic              sync_q, sync_n;
  logic              sclk_q, sclk_n;
  logic              din_q, din_n;
  logic              busy_n;
  logic              overrun_n;
  logic [FRAME_W-1:0] shreg, shreg_n;
  logic [FRAME_W-1:0] frame;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [BIT_W-1:0]  bit_cnt, bit_n;
  logic              pend_valid, pend_valid_n;
  logic [DATA_W-1:0] pend_word, pend_word_n;

  assign bus.SYNC = sync_q;
  assign bus.SCLK = sclk_q;
  assign bus.DIN  = din_q;

  always_ff @(posedge dataclk) begin
    if (reset) begin
      state      <= IDLE;
      sync_q     <= 1'b1;
      sclk_q     <= 1'b0;
      din_q      <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      shreg      <= '0;
      cnt        <= '0;
      bit_cnt    <= '0;
      pend_valid <= 1'b0;
      pend_word  <= '0;
    end else begin
      state      <= state_n;
      sync_q     <= sync_n;
      sclk_q     <= sclk_n;
      din_q      <= din_n;
      busy       <= busy_n;
      overrun    <= overrun_n;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      bit_cnt    <= bit_n;
      pend_valid <= pend_valid_n;
      pend_word  <= pend_word_n;
    end
  end

  // A fresh word in IDLE beats a stale pending one; DIN changes only as SCLK rises.
  always_comb begin
    state_n      = state;
    sync_n       = sync_q;
    sclk_n       = sclk_q;
    din_n        = din_q;
    busy_n       = busy;
    overrun_n    = 1'b0;
    shreg_n      = shreg;
    cnt_n        = cnt;
    bit_n        = bit_cnt;
    pend_valid_n = pend_valid;
    pend_word_n  = pend_word;
    frame        = {{SPI_CTRL_W{1'b0}}, (valid2 ? word_new : pend_word)};

    if (valid2 && (state != IDLE)) begin
      pend_word_n  = word_new;
      pend_valid_n = 1'b1;
      overrun_n    = pend_valid;
    end

    case (state)
      IDLE: begin
        if (valid2 || pend_valid) begin
          overrun_n    = valid2 && pend_valid;
          pend_valid_n = 1'b0;
          din_n        = frame[FRAME_W-1];
          shreg_n      = frame << 1;
          sync_n       = 1'b0;
          sclk_n       = 1'b1;
          busy_n       = 1'b1;
          cnt_n        = '0;
          bit_n        = '0;
          state_n      = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (cnt == CNT_W'(SCLK_DIV - 1)) begin
          cnt_n   = '0;
          sclk_n  = 1'b0;
          state_n = SHIFT_LO;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHIFT_LO: begin
        if (cnt == CNT_W'(SCLK_DIV - 1)) begin
          cnt_n = '0;
          if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
            sync_n  = 1'b1;
            din_n   = 1'b0;
            state_n = GAP;
          end else begin
            bit_n   = bit_cnt + 1'b1;
            din_n   = shreg[FRAME_W-1];
            shreg_n = shreg << 1;
            sclk_n  = 1'b1;
            state_n = SHIFT_HI;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == CNT_W'(SYNC_GAP - 1)) begin
          cnt_n   = '0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dac_channel_pipeline.sv
// Randomized and directed checks of dac_channel_pipeline against an arithmetic reference model
// and an SPI frame decoder watching SYNC/SCLK/DIN.
module tb_dac_channel_pipeline;

  logic        dataclk = 1'b0;
  logic        reset;
  logic        ref_en;
  logic [15:0] software_reference;
  logic        filter_en;
  logic        filter_type;
  logic [15:0] filter_coefficient;
  logic [6:0]  noise_suppress;
  logic [2:0]  gain;
  logic        en;
  logic        use_sequencer;
  logic [15:0] sequencer_in;
  logic [15:0] thrsh;
  logic [15:0] hyst;
  logic        thrsh_pol;
  logic [15:0] refractory;
  logic        thrsh_out;
  logic        thrsh_event;
  logic [15:0] register;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  dac_channel_pipeline_if #(.DATA_W(16)) bus ();

  always #5 dataclk = ~dataclk;

  dac_channel_pipeline dut (
    .dataclk            (dataclk),
    .reset              (reset),
    .bus                (bus),
    .ref_en             (ref_en),
    .software_reference (software_reference),
    .filter_en          (filter_en),
    .filter_type        (filter_type),
    .filter_coefficient (filter_coefficient),
    .noise_suppress     (noise_suppress),
    .gain               (gain),
    .en                 (en),
    .use_sequencer      (use_sequencer),
    .sequencer_in       (sequencer_in),
    .thrsh              (thrsh),
    .hyst               (hyst),
    .thrsh_pol          (thrsh_pol),
    .refractory         (refractory),
    .thrsh_out          (thrsh_out),
    .thrsh_event        (thrsh_event),
    .register           (register),
    .busy               (busy),
    .overrun            (overrun)
  );

  // SPI decoder: DAC samples DIN on SCLK falling edges while SYNC is low.
  logic [23:0] frames[$];
  logic [23:0] mon_shreg = '0;
  int          mon_nbits = 0;
  int          aborted   = 0;
  int          overruns  = 0;
  logic        prev_sync = 1'b1;
  logic        prev_sclk = 1'b0;

  always @(negedge dataclk) begin
    if (bus.SYNC === 1'b0) begin
      if (prev_sclk && !bus.SCLK) begin
        mon_shreg = {mon_shreg[22:0], bus.DIN};
        mon_nbits++;
      end
    end else if (prev_sync === 1'b0) begin
      if (mon_nbits == 24) frames.push_back(mon_shreg);
      else aborted++;
      mon_nbits = 0;
    end
    prev_sync = bus.SYNC;
    prev_sclk = bus.SCLK;
    if (overrun === 1'b1) overruns++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  longint m_s;
  logic   m_out;
  int     m_ref;

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_step(input logic [15:0] smp, output logic [15:0] reg_e,
                            output logic out_e, output logic ev_e);
    longint x, r, shi, dd, y, mag, vs, sc;
    int vob, th, lo, hi;
    x = longint'(smp) - 32768;
    if (ref_en) begin
      r = longint'(software_reference) - 32768;
      x = clamp(x - r, -32768, 32767);
    end
    if (filter_en) begin
      shi = m_s >>> 16;
      dd  = x - shi;
      y   = filter_type ? clamp(dd, -32768, 32767) : shi;
      m_s = m_s + dd * longint'(filter_coefficient);
    end else begin
      y = x;
    end
    mag = (y < 0) ? -y : y;
    mag = mag - longint'(noise_suppress) * 16;
    if (mag < 0) mag = 0;
    vs = (y < 0) ? -mag : mag;
    sc = clamp(vs * (longint'(1) << gain), -32768, 32767);
    if (use_sequencer) reg_e = sequencer_in;
    else if (en) reg_e = 16'(sc + 32768);
    else reg_e = 16'h8000;
    vob = int'(vs) + 32768;
    th  = int'(thrsh);
    lo  = th - int'(hyst);
    if (lo < 0) lo = 0;
    hi  = th + int'(hyst);
    if (hi > 65535) hi = 65535;
    if (m_ref > 0) m_ref--;
    ev_e = 1'b0;
    if (!en) m_out = 1'b0;
    else if (!m_out && (thrsh_pol ? (vob >= th) : (vob <= th))) begin
      m_out = 1'b1;
      if (m_ref == 0) begin
        ev_e  = 1'b1;
        m_ref = int'(refractory);
      end
    end else if (m_out && (thrsh_pol ? (vob < lo) : (vob > hi))) m_out = 1'b0;
    out_e = m_out;
  endtask

  task automatic set_defaults();
    ref_en = 0; software_reference = 16'h8000; filter_en = 0; filter_type = 0;
    filter_coefficient = 0; noise_suppress = 0; gain = 0; en = 1; use_sequencer = 0;
    sequencer_in = 0; thrsh = 16'hFFFF; hyst = 0; thrsh_pol = 1; refractory = 0;
  endtask

  task automatic do_reset();
    @(negedge dataclk);
    reset = 1; bus.sample_valid = 0; bus.sample_in = 0;
    repeat (2) @(negedge dataclk);
    reset = 0;
    m_s = 0; m_out = 0; m_ref = 0;
  endtask

  // One isolated sample: strobe, let it reach the output stage, compare with the model.
  task automatic applyStimulus(input logic [15:0] smp, input string tag);
    logic [15:0] reg_e;
    logic out_e, ev_e;
    int evs;
    model_step(smp, reg_e, out_e, ev_e);
    @(negedge dataclk);
    bus.sample_valid = 1; bus.sample_in = smp;
    evs = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge dataclk);
      bus.sample_valid = 0;
      if (thrsh_event) evs++;
    end
    checkOutput({tag, "_reg"}, 32'(register), 32'(reg_e));
    checkOutput({tag, "_thr"}, 32'(thrsh_out), 32'(out_e));
    checkOutput({tag, "_evt"}, 32'(evs), 32'(ev_e));
  endtask

  task automatic burst(input int n, input logic [15:0] smp, output logic [15:0] last_e);
    logic out_e, ev_e;
    for (int i = 0; i < n; i++) begin
      @(negedge dataclk);
      bus.sample_valid = 1; bus.sample_in = smp;
      model_step(smp, last_e, out_e, ev_e);
    end
    @(negedge dataclk);
    bus.sample_valid = 0;
    repeat (4) @(negedge dataclk);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] last_e;
    logic [15:0] w1, w2, w3;
    logic        exp_out [5];
    logic        exp_ev  [5];
    logic        got_out [5];
    logic        got_ev  [5];
    logic [15:0] seq4    [5];
    logic        reached;

    set_defaults();
    reset = 1; bus.sample_valid = 0; bus.sample_in = 0;
    do_reset();

    // Reset state
    checkOutput("rst_sync", 32'(bus.SYNC), 32'd1);
    checkOutput("rst_sclk", 32'(bus.SCLK), 32'd0);
    checkOutput("rst_din", 32'(bus.DIN), 32'd0);
    checkOutput("rst_reg", 32'(register), 32'h8000);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_thr", 32'(thrsh_out), 32'd0);

    // First frame carries the control byte and the word, MSB first
    frames.delete();
    applyStimulus(16'h9000, "t1");
    checkOutput("t1_reg_const", 32'(register), 32'h9000);
    repeat (120) @(negedge dataclk);
    checkOutput("t1_nframes", 32'(frames.size()), 32'd1);
    checkOutput("t1_frame", 32'(frames.size() > 0 ? frames[0] : 24'hFFFFFF), 32'h009000);
    checkOutput("t1_idle", 32'(busy), 32'd0);

    // HPF decay and LPF settling
    filter_en = 1; filter_type = 1; filter_coefficient = 16'h0100;
    burst(4096, 16'hA000, last_e);
    checkOutput("hpf_model", 32'(register), 32'(last_e));
    checkOutput("hpf_range", 32'(register >= 16'h7FF0 && register <= 16'h8010), 32'd1);
    do_reset();
    filter_type = 0;
    burst(4096, 16'hA000, last_e);
    checkOutput("lpf_model", 32'(register), 32'(last_e));
    checkOutput("lpf_range", 32'(register >= 16'h9FF0 && register <= 16'hA010), 32'd1);

    // Gain saturation and dead band
    do_reset();
    set_defaults();
    gain = 7;
    applyStimulus(16'h8400, "gain");
    checkOutput("gain_sat", 32'(register), 32'hFFFF);
    gain = 3'd7;
    applyStimulus(16'h7000, "gain_neg");
    checkOutput("gain_sat_neg", 32'(register), 32'h0000);
    gain = 0; noise_suppress = 2;
    applyStimulus(16'h8010, "supp");
    checkOutput("supp_zero", 32'(register), 32'h8000);

    // Hysteresis and refractory on back-to-back samples
    do_reset();
    set_defaults();
    thrsh_pol = 1; thrsh = 16'h9000; hyst = 16'h0100; refractory = 16'd3;
    seq4    = '{16'h9000, 16'h8F80, 16'h9000, 16'h8E00, 16'h9000};
    exp_out = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_ev  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int j = 0; j < 10; j++) begin
      @(negedge dataclk);
      if (j >= 3 && j < 8) begin
        got_out[j-3] = thrsh_out;
        got_ev[j-3]  = thrsh_event;
      end
      if (j < 5) begin
        bus.sample_valid = 1; bus.sample_in = seq4[j];
      end else begin
        bus.sample_valid = 0;
      end
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hyst_out%0d", i), 32'(got_out[i]), 32'(exp_out[i]));
      checkOutput($sformatf("hyst_evt%0d", i), 32'(got_ev[i]), 32'(exp_ev[i]));
    end

    // Overrun: three words two cycles apart, only first and last are sent
    do_reset();
    set_defaults();
    frames.delete();
    overruns = 0;
    w1 = 16'($urandom); w2 = 16'($urandom); w3 = 16'($urandom);
    @(negedge dataclk); bus.sample_valid = 1; bus.sample_in = w1;
    @(negedge dataclk); bus.sample_valid = 0;
    @(negedge dataclk); bus.sample_valid = 1; bus.sample_in = w2;
    @(negedge dataclk); bus.sample_valid = 0;
    @(negedge dataclk); bus.sample_valid = 1; bus.sample_in = w3;
    @(negedge dataclk); bus.sample_valid = 0;
    repeat (300) @(negedge dataclk);
    checkOutput("ovr_nframes", 32'(frames.size()), 32'd2);
    checkOutput("ovr_frame0", 32'(frames.size() > 0 ? frames[0] : 24'hFFFFFF), 32'({8'h00, w1}));
    checkOutput("ovr_frame1", 32'(frames.size() > 1 ? frames[1] : 24'hFFFFFF), 32'({8'h00, w3}));
    checkOutput("ovr_pulses", 32'(overruns), 32'd1);
    checkOutput("ovr_reg", 32'(register), 32'(w3));

    // Reset in the middle of a frame aborts it without resend
    do_reset();
    set_defaults();
    frames.delete();
    aborted = 0;
    @(negedge dataclk); bus.sample_valid = 1; bus.sample_in = 16'h5A5A;
    @(negedge dataclk); bus.sample_valid = 0;
    reached = 0;
    for (int c = 0; c < 200 && !reached; c++) begin
      @(negedge dataclk);
      if (mon_nbits >= 10) reached = 1;
    end
    checkOutput("abort_reach_bit10", 32'(reached), 32'd1);
    checkOutput("abort_busy_mid", 32'(busy), 32'd1);
    reset = 1;
    @(negedge dataclk);
    checkOutput("abort_sync", 32'(bus.SYNC), 32'd1);
    checkOutput("abort_sclk", 32'(bus.SCLK), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    reset = 0;
    m_s = 0; m_out = 0; m_ref = 0;
    repeat (300) @(negedge dataclk);
    checkOutput("abort_noresend", 32'(frames.size()), 32'd0);
    checkOutput("abort_count", 32'(aborted), 32'd1);

    // Randomized settings and samples against the model
    do_reset();
    set_defaults();
    for (int n = 0; n < 80; n++) begin
      if (n % 4 == 0) begin
        ref_en             = 1'($urandom_range(0, 1));
        software_reference = 16'($urandom_range(16'h6000, 16'hA000));
        filter_en          = 1'($urandom_range(0, 1));
        filter_type        = 1'($urandom_range(0, 1));
        filter_coefficient = 16'($urandom);
        noise_suppress     = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom);
        gain               = 3'($urandom);
        en                 = ($urandom_range(0, 9) != 0);
        use_sequencer      = ($urandom_range(0, 9) == 0);
        sequencer_in       = 16'($urandom);
        thrsh              = 16'($urandom_range(16'h4000, 16'hC000));
        hyst               = 16'($urandom_range(0, 16'h2000));
        thrsh_pol          = 1'($urandom_range(0, 1));
        refractory         = 16'($urandom_range(0, 3));
      end
      applyStimulus(16'($urandom), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
